// File: rtl/switch_debouncer.sv
// switch_debouncer
// Synchronises and debounces the board slide switches and buttons.
// Each channel has a two-flop synchroniser and its own stability FSM with a counter.
// The FSM produces a clean level plus one-cycle rise and fall pulses.
// Channel 0 is the write-block select (switch0). Channel 1 is the read-block select (switch1).
module switch_debouncer #(
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] switch_raw,
  output logic [CHANNELS-1:0] switch_clean,
  output logic [CHANNELS-1:0] switch_rise,
  output logic [CHANNELS-1:0] switch_fall,
  output logic                switch_changed
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t              state      [CHANNELS];
  state_t              state_next [CHANNELS];
  logic [CW-1:0]       cnt        [CHANNELS];
  logic [CW-1:0]       cnt_next   [CHANNELS];
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] clean_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;

  // Two-flop synchroniser that brings the asynchronous pins into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
    end
  end

  // State register: holds each channel's FSM state and stability counter
  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  // Next-state logic: a WAIT state commits once the counter reaches its last value
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        STABLE_LOW:  if (sync2[i]) state_next[i] = WAIT_HIGH;
        WAIT_HIGH: begin
          if (!sync2[i])        state_next[i] = STABLE_LOW;
          else if (cnt[i] == LAST) state_next[i] = STABLE_HIGH;
        end
        STABLE_HIGH: if (!sync2[i]) state_next[i] = WAIT_LOW;
        WAIT_LOW: begin
          if (sync2[i])         state_next[i] = STABLE_HIGH;
          else if (cnt[i] == LAST) state_next[i] = STABLE_LOW;
        end
        default: state_next[i] = STABLE_LOW;
      endcase
    end
  end

  // Output logic: counter advance, next clean level, and the edge pulses set on a committed transition
  always_comb begin
    clean_next = switch_clean;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next[i] = '0;
      case (state[i])
        WAIT_HIGH: begin
          if (sync2[i]) begin
            if (cnt[i] == LAST) begin
              clean_next[i] = 1'b1;
              rise_next[i]  = 1'b1;
            end else begin
              cnt_next[i] = cnt[i] + CW'(1);
            end
          end
        end
        WAIT_LOW: begin
          if (!sync2[i]) begin
            if (cnt[i] == LAST) begin
              clean_next[i] = 1'b0;
              fall_next[i]  = 1'b1;
            end else begin
              cnt_next[i] = cnt[i] + CW'(1);
            end
          end
        end
        default: cnt_next[i] = '0;
      endcase
    end
  end

  // Registered outputs, so the pulses last exactly one cycle after the committing edge
  always_ff @(posedge clock) begin
    if (reset) begin
      switch_clean   <= '0;
      switch_rise    <= '0;
      switch_fall    <= '0;
      switch_changed <= 1'b0;
    end else begin
      switch_clean   <= clean_next;
      switch_rise    <= rise_next;
      switch_fall    <= fall_next;
      switch_changed <= |(rise_next | fall_next);
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Directed and randomised stimulus for switch_debouncer with STABLE_CYCLES=4 and CHANNELS=2.
// A run-length model of the debounce rule is compared against the DUT on every cycle.
// Hand-computed literal checks at key points pin the model itself.
module tb_switch_debouncer;

  localparam int CH = 2;
  localparam int SC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] switch_raw = '0;
  logic [CH-1:0] switch_clean;
  logic [CH-1:0] switch_rise;
  logic [CH-1:0] switch_fall;
  logic          switch_changed;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [CH-1:0] m_pin_a;
  logic [CH-1:0] m_pin_b;
  logic [CH-1:0] m_clean;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  logic          run_val [CH];
  int            run_len [CH];
  logic          seen;

  switch_debouncer #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .switch_raw     (switch_raw),
    .switch_clean   (switch_clean),
    .switch_rise    (switch_rise),
    .switch_fall    (switch_fall),
    .switch_changed (switch_changed)
  );

  // Free-running clock with a 10-unit period
  always #5 clock = ~clock;

  // Behavioural model: the clean level flips once the pin, seen two cycles late, holds a new value for SC+1 samples
  always @(posedge clock) begin
    if (reset) begin
      m_pin_a = '0;
      m_pin_b = '0;
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < CH; i++) begin
        run_val[i] = 1'b0;
        run_len[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        seen       = m_pin_b[i];
        m_pin_b[i] = m_pin_a[i];
        m_pin_a[i] = switch_raw[i];
        m_rise[i]  = 1'b0;
        m_fall[i]  = 1'b0;
        if (seen == run_val[i]) begin
          if (run_len[i] <= SC) run_len[i]++;
        end else begin
          run_val[i] = seen;
          run_len[i] = 1;
        end
        if (run_len[i] >= SC + 1 && run_val[i] != m_clean[i]) begin
          m_clean[i] = run_val[i];
          if (run_val[i]) m_rise[i] = 1'b1;
          else            m_fall[i] = 1'b1;
        end
      end
    end
  end

  // Compares one value against its expectation and counts the result
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances n cycles, which leaves the bench just past a falling edge
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Changes the pin levels at a falling edge so the next rising edge samples them
  task automatic apply_stimulus(input logic [CH-1:0] value);
    switch_raw = value;
  endtask

  // Returns to the post-reset state with all pins low
  task automatic do_reset();
    apply_stimulus('0);
    reset = 1'b1;
    wait_edges(2);
    reset = 1'b0;
    wait_edges(2);
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clock) begin
    if (check_en) begin
      check_output("model_clean",   switch_clean,   m_clean);
      check_output("model_rise",    switch_rise,    m_rise);
      check_output("model_fall",    switch_fall,    m_fall);
      check_output("model_changed", switch_changed, |(m_rise | m_fall));
    end
  end

  // Directed scenarios followed by a randomised bounce phase
  initial begin
    logic pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with pins high, then debounce from scratch
    reset = 1'b1;
    apply_stimulus(2'b11);
    wait_edges(3);
    check_en = 1'b1;
    check_output("reset_clean",   switch_clean,   0);
    check_output("reset_rise",    switch_rise,    0);
    check_output("reset_fall",    switch_fall,    0);
    check_output("reset_changed", switch_changed, 0);
    reset = 1'b0;
    wait_edges(6);
    check_output("rst_rel_clean_early", switch_clean, 2'b00);
    wait_edges(1);
    check_output("rst_rel_clean",   switch_clean,   2'b11);
    check_output("rst_rel_rise",    switch_rise,    2'b11);
    check_output("rst_rel_changed", switch_changed, 1);
    wait_edges(1);
    check_output("rst_rel_rise_clear", switch_rise,    2'b00);
    check_output("rst_rel_chg_clear",  switch_changed, 0);

    // Clean press on channel 0
    do_reset();
    apply_stimulus(2'b01);
    wait_edges(6);
    check_output("press_clean_early", switch_clean, 2'b00);
    wait_edges(1);
    check_output("press_clean", switch_clean, 2'b01);
    check_output("press_rise",  switch_rise,  2'b01);
    wait_edges(1);
    check_output("press_rise_clear", switch_rise, 2'b00);

    // Release on channel 0
    apply_stimulus(2'b00);
    wait_edges(6);
    check_output("release_clean_early", switch_clean, 2'b01);
    wait_edges(1);
    check_output("release_clean", switch_clean, 2'b00);
    check_output("release_fall",  switch_fall,  2'b01);
    check_output("release_rise",  switch_rise,  2'b00);
    wait_edges(1);
    check_output("release_fall_clear", switch_fall, 2'b00);

    // Bounce rejection, then a run just long enough to commit
    do_reset();
    for (int k = 0; k < 8; k++) begin
      apply_stimulus({1'b0, pat[k]});
      wait_edges(1);
      check_output("bounce_clean", switch_clean, 2'b00);
      check_output("bounce_rise",  switch_rise,  2'b00);
    end
    apply_stimulus(2'b00);
    for (int k = 0; k < 8; k++) begin
      wait_edges(1);
      check_output("bounce_tail_clean", switch_clean, 2'b00);
      check_output("bounce_tail_rise",  switch_rise,  2'b00);
    end
    apply_stimulus(2'b01);
    wait_edges(5);
    apply_stimulus(2'b00);
    wait_edges(1);
    check_output("run5_clean_early", switch_clean, 2'b00);
    wait_edges(1);
    check_output("run5_clean", switch_clean, 2'b01);
    check_output("run5_rise",  switch_rise,  2'b01);
    wait_edges(10);
    check_output("run5_settle", switch_clean, 2'b00);

    // Simultaneous channels
    do_reset();
    apply_stimulus(2'b11);
    wait_edges(7);
    check_output("simul_rise",    switch_rise,    2'b11);
    check_output("simul_changed", switch_changed, 1);
    wait_edges(1);
    check_output("simul_chg_clear", switch_changed, 0);
    apply_stimulus(2'b01);
    wait_edges(7);
    check_output("ch1_fall", switch_fall, 2'b10);
    check_output("ch1_rise", switch_rise, 2'b00);
    check_output("ch1_clean", switch_clean, 2'b01);

    // Reset while channel 0 is waiting
    do_reset();
    apply_stimulus(2'b01);
    wait_edges(4);
    check_output("midwait_no_rise", switch_rise, 2'b00);
    reset = 1'b1;
    wait_edges(1);
    check_output("midwait_clean_rst", switch_clean, 2'b00);
    reset = 1'b0;
    wait_edges(6);
    check_output("midwait_clean_early", switch_clean, 2'b00);
    wait_edges(1);
    check_output("midwait_clean", switch_clean, 2'b01);
    check_output("midwait_rise",  switch_rise,  2'b01);

    // Random bounce phase checked only by the model
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(2'($urandom_range(0, 3)));
      wait_edges($urandom_range(1, 7));
    end
    wait_edges(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the board's slide switches and buttons before they reach the seven-segment display interface and the memory-block select logic. Each channel passes through a two-flop synchroniser and a per-channel stability state machine. Each channel produces a clean level plus single-cycle rise and fall pulses. Channel 0 carries the write-block select (switch0) and channel 1 carries the read-block select (switch1). The display interface consumes `switch_clean[1:0]` in place of raw pins.

## Interface

- `CHANNELS`, default 2: number of independent inputs.
- `STABLE_CYCLES`, default 1_000_000: cycles the synchronised input must hold before the clean level changes (10 ms at 100 MHz). Legal range is 1 or more. The counter width is derived as `$clog2(STABLE_CYCLES+1)`.

- `clock` in 1: system clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `switch_raw` in CHANNELS: asynchronous pin levels. Bit 0 is switch0 (write-block select) and bit 1 is switch1 (read-block select).
- `switch_clean` out CHANNELS: debounced level.
- `switch_rise` out CHANNELS: one-cycle pulse when the clean level goes 0→1.
- `switch_fall` out CHANNELS: one-cycle pulse when the clean level goes 1→0.
- `switch_changed` out 1: OR of all rise and fall bits in the same cycle.

## Operation

- **Synchroniser.** Each channel has a two-flop chain `sync1 → sync2`. The FSM sees only `sync2`.
- **Per-channel FSM.** States are STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW. Each channel has its own counter `cnt`.
  - STABLE_LOW: if `sync2`=1, go to WAIT_HIGH with `cnt`←0. Otherwise stay.
  - WAIT_HIGH: if `sync2`=0 (bounce), return to STABLE_LOW with `cnt`←0 and no output change.
  - WAIT_HIGH: else if `cnt`==STABLE_CYCLES-1, go to STABLE_HIGH, set `switch_clean`←1 and `switch_rise`←1.
  - WAIT_HIGH: else `cnt`←`cnt`+1.
  - STABLE_HIGH and WAIT_LOW mirror the above with polarity inverted, and assert `switch_fall` on entry to STABLE_LOW.
- **Output timing.** All outputs are registered. A pulse is high for exactly the one cycle after the transition edge, then cleared.
- **Channel independence.** Channels are fully independent. Simultaneous transitions on several channels assert several pulse bits in the same cycle, and `switch_changed` is then a single 1.
- **Counter range.** `cnt` never exceeds STABLE_CYCLES-1 and never wraps. It holds 0 in the STABLE states.
- **STABLE_CYCLES=1.** The WAIT state lasts exactly one cycle.

## Timing

- **Reset values.** On a clock edge with `reset`=1, all of the following are forced regardless of `switch_raw`:
  - `sync1`, `sync2`, `cnt` = 0
  - every FSM = STABLE_LOW
  - `switch_clean` = 0, `switch_rise` = 0, `switch_fall` = 0, `switch_changed` = 0
- **Latency.** Let `switch_raw[i]` first be sampled 1 at edge t0 and stay 1. Then:
  - `sync2` is 1 after t0+1.
  - The FSM enters WAIT_HIGH at t0+2.
  - `switch_clean[i]` and `switch_rise[i]` go 1 after edge t0+2+STABLE_CYCLES.
  - `switch_rise[i]` returns to 0 after the next edge.
  - Total latency is STABLE_CYCLES+2 cycles. Falling edges are symmetric.
- **Glitch rejection.** A `sync2` pulse of STABLE_CYCLES cycles or fewer produces no output change. A pulse of STABLE_CYCLES+1 cycles always does.
- **Reset mid-WAIT.** The count is discarded and the clean level returns to 0.
- **Raw held high through reset.** After `reset` deasserts, the debounce restarts from scratch: `switch_clean` rises STABLE_CYCLES+2 cycles after the first edge with `reset`=0, together with a rise pulse.
- **Pulse overlap.** Rise and fall on the same channel can never overlap. The minimum spacing between them is STABLE_CYCLES+1 cycles.

## Test plan

All scenarios use STABLE_CYCLES=4 and CHANNELS=2.

1. **Reset.** Hold `reset`=1 for 3 cycles with `switch_raw`=2'b11. Required: all outputs 0. Release reset. Required: `switch_clean` becomes 2'b11 exactly 6 edges after the first non-reset edge, `switch_rise`=2'b11 for 1 cycle, and `switch_changed`=1 for that same cycle.
2. **Clean press.** Step `switch_raw[0]` 0→1 at t0 and hold it. Required: `switch_clean[0]`=1 and a single `switch_rise[0]` pulse after edge t0+6. `switch_clean[1]` stays 0 with no pulses.
3. **Bounce rejection.** Drive `switch_raw[0]` with the pattern 1,1,1,1,0,1,1,0 (sampled per cycle) and then 0. Required: `switch_clean[0]` stays 0 and no pulses occur. A following run of five 1s must produce a rise 6 cycles after the run starts.
4. **Release.** From `switch_clean[0]`=1, drop `switch_raw[0]` to 0 at t1. Required: `switch_clean[0]`=0 and `switch_fall[0]` high for one cycle after edge t1+6, with no rise pulse.
5. **Simultaneous channels.** Step `switch_raw` 2'b00→2'b11 in the same cycle. Required: `switch_rise`=2'b11 in a single cycle and `switch_changed` high for exactly one cycle. Then step channel 1 alone to 0. Required: `switch_fall`=2'b10 only.
6. **Reset mid-WAIT.** Raise `switch_raw[0]`, then assert `reset` for 1 cycle at t0+4 while still holding raw high. Required: no rise pulse before reset. After release, `switch_clean[0]` rises 6 edges after the first non-reset edge.
